// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold.
// Optional bubble counter is built when IDEX_BUBBLE_CNT_EN is defined.
//
// Ports:
//   I_CLK, I_RESET_N                   clock, async active-low reset
//   I_IDEX_FLUSH / I_IDEX_HOLD          bubble (taken branch) / freeze
//   I_IDEX_CTRL, PC4, RSDATA, RTDATA,   decode-side bundle captured each
//   IMM, RS, RT, RD, SHAMT              cycle and presented as O_IDEX_*
//   O_IDEX_VALID                        1 = real instruction in EX
//   O_IDEX_STALL                        combinational load-use stall
//   O_IDEX_BUBBLES (IDEX_BUBBLE_CNT_EN) saturating bubble count
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          I_CLK,
    input  logic          I_RESET_N,
    input  logic          I_IDEX_FLUSH,
    input  logic          I_IDEX_HOLD,
    input  logic [19:0]   I_IDEX_CTRL,
    input  logic [DW-1:0] I_IDEX_PC4,
    input  logic [DW-1:0] I_IDEX_RSDATA,
    input  logic [DW-1:0] I_IDEX_RTDATA,
    input  logic [DW-1:0] I_IDEX_IMM,
    input  logic [RW-1:0] I_IDEX_RS,
    input  logic [RW-1:0] I_IDEX_RT,
    input  logic [RW-1:0] I_IDEX_RD,
    input  logic [4:0]    I_IDEX_SHAMT,
    output logic [19:0]   O_IDEX_CTRL,
    output logic [DW-1:0] O_IDEX_PC4,
    output logic [DW-1:0] O_IDEX_RSDATA,
    output logic [DW-1:0] O_IDEX_RTDATA,
    output logic [DW-1:0] O_IDEX_IMM,
    output logic [RW-1:0] O_IDEX_RS,
    output logic [RW-1:0] O_IDEX_RT,
    output logic [RW-1:0] O_IDEX_RD,
    output logic [4:0]    O_IDEX_SHAMT,
    output logic          O_IDEX_VALID,
`ifdef IDEX_BUBBLE_CNT_EN
    output logic [15:0]   O_IDEX_BUBBLES,
`endif
    output logic          O_IDEX_STALL
);

    localparam int MEMREAD_BIT = 16;

    logic haz;

    // EX holds a load whose destination is read by the ID instruction.
    assign haz = O_IDEX_VALID
               & O_IDEX_CTRL[MEMREAD_BIT]
               & (O_IDEX_RT != '0)
               & ((O_IDEX_RT == I_IDEX_RS) | (O_IDEX_RT == I_IDEX_RT));

    // A flushed ID instruction is discarded, so it never needs a stall.
    assign O_IDEX_STALL = haz & ~I_IDEX_FLUSH;

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            O_IDEX_CTRL   <= '0;
            O_IDEX_PC4    <= '0;
            O_IDEX_RSDATA <= '0;
            O_IDEX_RTDATA <= '0;
            O_IDEX_IMM    <= '0;
            O_IDEX_RS     <= '0;
            O_IDEX_RT     <= '0;
            O_IDEX_RD     <= '0;
            O_IDEX_SHAMT  <= '0;
            O_IDEX_VALID  <= 1'b0;
        end else if (I_IDEX_FLUSH || (!I_IDEX_HOLD && haz)) begin
            // Bubble: zeroed fields keep RegWrite/MemWrite/MemRead off,
            // which also ends the load-use stall after one cycle.
            O_IDEX_CTRL   <= '0;
            O_IDEX_PC4    <= '0;
            O_IDEX_RSDATA <= '0;
            O_IDEX_RTDATA <= '0;
            O_IDEX_IMM    <= '0;
            O_IDEX_RS     <= '0;
            O_IDEX_RT     <= '0;
            O_IDEX_RD     <= '0;
            O_IDEX_SHAMT  <= '0;
            O_IDEX_VALID  <= 1'b0;
        end else if (!I_IDEX_HOLD) begin
            O_IDEX_CTRL   <= I_IDEX_CTRL;
            O_IDEX_PC4    <= I_IDEX_PC4;
            O_IDEX_RSDATA <= I_IDEX_RSDATA;
            O_IDEX_RTDATA <= I_IDEX_RTDATA;
            O_IDEX_IMM    <= I_IDEX_IMM;
            O_IDEX_RS     <= I_IDEX_RS;
            O_IDEX_RT     <= I_IDEX_RT;
            O_IDEX_RD     <= I_IDEX_RD;
            O_IDEX_SHAMT  <= I_IDEX_SHAMT;
            O_IDEX_VALID  <= 1'b1;
        end
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic        bubble_ev;
    logic [15:0] bub_q;

    assign bubble_ev      = I_IDEX_FLUSH | (~I_IDEX_HOLD & haz);
    assign O_IDEX_BUBBLES = bub_q;

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            bub_q <= '0;
        end else if (bubble_ev && (bub_q != 16'hFFFF)) begin
            bub_q <= bub_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random
// traffic compared against a behavioural model of the pipeline register.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        hold;
    logic [19:0] ctrl;
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd, shamt;

    logic [19:0] o_ctrl;
    logic [31:0] o_pc4, o_rsd, o_rtd, o_imm;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic        o_valid, o_stall;
`ifdef IDEX_BUBBLE_CNT_EN
    logic [15:0] o_bub;
`endif

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .I_CLK         (clk),
        .I_RESET_N     (rst_n),
        .I_IDEX_FLUSH  (flush),
        .I_IDEX_HOLD   (hold),
        .I_IDEX_CTRL   (ctrl),
        .I_IDEX_PC4    (pc4),
        .I_IDEX_RSDATA (rsd),
        .I_IDEX_RTDATA (rtd),
        .I_IDEX_IMM    (imm),
        .I_IDEX_RS     (rs),
        .I_IDEX_RT     (rt),
        .I_IDEX_RD     (rd),
        .I_IDEX_SHAMT  (shamt),
        .O_IDEX_CTRL   (o_ctrl),
        .O_IDEX_PC4    (o_pc4),
        .O_IDEX_RSDATA (o_rsd),
        .O_IDEX_RTDATA (o_rtd),
        .O_IDEX_IMM    (o_imm),
        .O_IDEX_RS     (o_rs),
        .O_IDEX_RT     (o_rt),
        .O_IDEX_RD     (o_rd),
        .O_IDEX_SHAMT  (o_shamt),
        .O_IDEX_VALID  (o_valid),
`ifdef IDEX_BUBBLE_CNT_EN
        .O_IDEX_BUBBLES(o_bub),
`endif
        .O_IDEX_STALL  (o_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model state: what EX should hold, as one record.
    typedef struct packed {
        logic [19:0] ctrl;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        valid;
    } ex_t;

    ex_t m;
    int  m_bub;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic m_haz();
        return m.valid && m.ctrl[16] && (m.rt != 0)
            && (m.rt == rs || m.rt == rt);
    endfunction

    task automatic m_reset();
        m     = '0;
        m_bub = 0;
    endtask

    task automatic m_edge();
        if (flush || (!hold && m_haz())) begin
            m = '0;
            if (m_bub < 65535) m_bub++;
        end else if (!hold) begin
            m = '{ctrl, pc4, rsd, rtd, imm, rs, rt, rd, shamt, 1'b1};
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_ctrl"},  {12'h0, o_ctrl}, {12'h0, m.ctrl});
        chk({tag, "_pc4"},   o_pc4, m.pc4);
        chk({tag, "_rsd"},   o_rsd, m.rsd);
        chk({tag, "_rtd"},   o_rtd, m.rtd);
        chk({tag, "_imm"},   o_imm, m.imm);
        chk({tag, "_idx"},   {12'h0, o_rs, o_rt, o_rd, o_shamt},
                             {12'h0, m.rs, m.rt, m.rd, m.shamt});
        chk({tag, "_valid"}, {31'h0, o_valid}, {31'h0, m.valid});
`ifdef IDEX_BUBBLE_CNT_EN
        chk({tag, "_bub"},   {16'h0, o_bub}, m_bub[31:0]);
`endif
    endtask

    // Inputs are set 1 time unit after a rising edge; check STALL
    // mid-cycle, then take the edge and check the registered outputs.
    task automatic cycle(input string tag);
        #2;
        chk({tag, "_stall"}, {31'h0, o_stall},
            {31'h0, m_haz() & ~flush});
        @(posedge clk);
        m_edge();
        #1;
        chk_out(tag);
    endtask

    task automatic rand_in();
        ctrl  = 20'($urandom);
        pc4   = $urandom;
        rsd   = $urandom;
        rtd   = $urandom;
        imm   = $urandom;
        rs    = 5'($urandom_range(0, 3));
        rt    = 5'($urandom_range(0, 3));
        rd    = 5'($urandom);
        shamt = 5'($urandom);
        flush = ($urandom_range(0, 9) == 0);
        hold  = ($urandom_range(0, 6) == 0);
    endtask

    task automatic set_lw(input logic [4:0] dst);
        ctrl  = 20'h50000;
        rt    = dst;
        rs    = 5'd9;
        flush = 1'b0;
        hold  = 1'b0;
    endtask

    ex_t snap;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        ctrl  = '0; pc4 = '0; rsd = '0; rtd = '0; imm = '0;
        rs = '0; rt = '0; rd = '0; shamt = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_out("rst0");
        rst_n = 1'b1;

        // Pass-through
        ctrl = 20'hA5A5A; rsd = 32'h1234; pc4 = 32'h104;
        rtd = 32'hBEEF; imm = 32'hFFFF_FFF0;
        rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd4;
        cycle("pt");
        chk("pt_ctrl_k", {12'h0, o_ctrl}, 32'h000A5A5A);
        chk("pt_rsd_k", o_rsd, 32'h1234);

        // Load-use with RT=5
        set_lw(5'd5);
        cycle("lw");
        rs = 5'd5; rt = 5'd7; ctrl = 20'h40000;
        #2;
        chk("lu_stall_k", {31'h0, o_stall}, 32'h1);
        cycle("lu");
        chk("lu_bubble_k", {11'h0, o_ctrl, o_valid}, 32'h0);
        cycle("lu_after");
        chk("lu_valid_k", {31'h0, o_valid}, 32'h1);

        // Load-use with RT=0 never stalls
        set_lw(5'd0);
        cycle("lw0");
        rs = 5'd0; rt = 5'd0;
        cycle("lu0");
        chk("lu0_valid_k", {31'h0, o_valid}, 32'h1);

        // Flush overrides hazard
        set_lw(5'd5);
        cycle("lwf");
        rs = 5'd5; flush = 1'b1;
        #2;
        chk("fl_stall_k", {31'h0, o_stall}, 32'h0);
        cycle("fl");
        flush = 1'b0;

        // Hold for 3 cycles with changing inputs
        rand_in(); flush = 1'b0; hold = 1'b0;
        cycle("hload");
        snap = m;
        for (int i = 0; i < 3; i++) begin
            rand_in(); flush = 1'b0; hold = 1'b1;
            cycle("hold");
        end
        chk("hold_ctrl_k", {12'h0, o_ctrl}, {12'h0, snap.ctrl});
        rand_in(); flush = 1'b0; hold = 1'b0; rs = 5'd30; rt = 5'd31;
        cycle("hrel");

        // Reset asserted mid-stall
        set_lw(5'd6);
        cycle("lwr");
        rs = 5'd6;
        #2;
        chk("rs_stall_pre", {31'h0, o_stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rs_stall", {31'h0, o_stall}, 32'h0);
        chk_out("rs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_in();
            cycle("rnd");
        end

`ifdef IDEX_BUBBLE_CNT_EN
        // Saturate the bubble counter
        flush = 1'b1; hold = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            m_edge();
        end
        #1;
        chk("sat_bub", {16'h0, o_bub}, 32'h0000FFFF);
        cycle("sat_more");
        flush = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
